// File: rtl/operand_loader_pkg.sv
// Shared constants for the operand loader: FSM state encoding and operand count.
package operand_loader_pkg;

   localparam int unsigned OP_COUNT = 4;
   localparam int unsigned IDX_W    = 2;
   localparam int unsigned CNT_W    = 4;

   typedef enum logic [2:0] {
      LOAD = 3'd0,
      CLR  = 3'd1,
      GO   = 3'd2,
      WAIT = 3'd3,
      HOLD = 3'd4
   } state_t;

endpackage

// File: rtl/operand_loader.sv
// Collects four operand bytes, clears and starts the compute stage, then waits
// for done (or a timeout) and holds the captured result until downstream accepts.
module operand_loader
   import operand_loader_pkg::*;
#(
   parameter int unsigned TIMEOUT = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic       in_mode,
   output logic       core_clr,
   output logic       start,
   output logic       mode,
   output logic [7:0] a,
   output logic [7:0] b,
   output logic [7:0] c,
   output logic [7:0] d,
   input  logic       done,
   input  logic [7:0] result,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       err
);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OP_COUNT - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] cnt;
   logic             xfer;
   logic             timed_out;

   assign xfer      = (state == LOAD) && in_valid;
   assign timed_out = (cnt == CNT_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= LOAD;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      core_clr  = 1'b0;
      start     = 1'b0;
      out_valid = 1'b0;
      case (state)
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid && (idx == IDX_LAST)) begin
               state_nxt = CLR;
            end
         end
         CLR: begin
            core_clr  = 1'b1;
            state_nxt = GO;
         end
         GO: begin
            start     = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (done || timed_out) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = LOAD;
            end
         end
         default: state_nxt = LOAD;
      endcase
   end

   // Operand capture: index walks a..d; mode rides along with byte 0 only.
   always_ff @(posedge clock) begin
      if (reset) begin
         idx  <= '0;
         a    <= '0;
         b    <= '0;
         c    <= '0;
         d    <= '0;
         mode <= 1'b0;
      end else if (xfer) begin
         case (idx)
            2'd0: begin
               a    <= in_data;
               mode <= in_mode;
            end
            2'd1:    b <= in_data;
            2'd2:    c <= in_data;
            default: d <= in_data;
         endcase
         idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
   end

   // done takes priority over the timeout on the final WAIT cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt      <= '0;
         out_data <= '0;
         err      <= 1'b0;
      end else begin
         if (state == GO) begin
            cnt <= '0;
         end else if (state == WAIT) begin
            if (done) begin
               out_data <= result;
               err      <= 1'b0;
            end else begin
               cnt <= cnt + 1'b1;
               if (timed_out) begin
                  out_data <= '0;
                  err      <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with a compute-stage stub whose done latency
// and result are set per test.
module tb_operand_loader;

   logic       clock = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_mode;
   logic       core_clr;
   logic       start;
   logic       mode;
   logic [7:0] a, b, c, d;
   logic       done;
   logic [7:0] result;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       err;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clock = ~clock;

   operand_loader #(.TIMEOUT(8)) dut (
      .clock    (clock),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_mode  (in_mode),
      .core_clr (core_clr),
      .start    (start),
      .mode     (mode),
      .a        (a),
      .b        (b),
      .c        (c),
      .d        (d),
      .done     (done),
      .result   (result),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .err      (err)
   );

   // Stub: stub_cyc is 1 in the cycle after start, done fires when it hits stub_lat.
   int         stub_cyc   = 0;
   int         stub_lat   = 4;
   logic       stub_en    = 1'b1;
   logic       force_done = 1'b0;
   logic [7:0] stub_res   = 8'h00;

   always @(posedge clock) begin
      if (reset || core_clr) stub_cyc <= 0;
      else if (start) stub_cyc <= 1;
      else if (stub_cyc != 0 && stub_cyc < 31) stub_cyc <= stub_cyc + 1;
   end

   always_comb begin
      done   = force_done | (stub_en && (stub_cyc == stub_lat));
      result = stub_res;
   end

   int clr_cnt   = 0;
   int start_cnt = 0;
   always @(posedge clock) begin
      if (core_clr) clr_cnt <= clr_cnt + 1;
      if (start) start_cnt <= start_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] data, input logic md);
      int g;
      in_data  = data;
      in_mode  = md;
      in_valid = 1'b1;
      g = 0;
      while (!in_ready && g < 50) begin
         tick();
         g++;
      end
      if (g >= 50) check("in_ready_wait", 32'd0, 32'd1);
      tick();
      in_valid = 1'b0;
      in_data  = 8'h00;
      in_mode  = 1'b0;
   endtask

   task automatic load_set(input logic [31:0] ops, input logic md);
      send_byte(ops[31:24], md);
      send_byte(ops[23:16], 1'b0);
      send_byte(ops[15:8], 1'b0);
      send_byte(ops[7:0], 1'b0);
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, s0, c0;
      reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_mode = 1'b0; out_ready = 1'b0;
      tick(); tick(); tick();
      reset = 1'b0;

      check("rst_in_ready", in_ready, 1);
      check("rst_pulses", {core_clr, start, out_valid, err}, 4'b0000);
      check("rst_out_data", out_data, 8'h00);
      check("rst_ops", {a, b, c, d}, 32'h0);
      check("rst_mode", mode, 0);

      // Nominal transaction
      stub_lat = 4; stub_res = 8'h5A; stub_en = 1'b1;
      c0 = clr_cnt; s0 = start_cnt;
      load_set(32'h0A140304, 1'b1);
      check("clr_cycle", {core_clr, start, in_ready}, 3'b100);
      tick();
      check("go_cycle", {core_clr, start, in_ready}, 3'b010);
      wait_out(n);
      check("nominal_latency", n + 1, 6);
      check("nominal_ops", {a, b, c, d}, 32'h0A140304);
      check("nominal_mode", mode, 1);
      check("nominal_data", out_data, 8'h5A);
      check("nominal_err", err, 0);
      check("nominal_clr_once", clr_cnt - c0, 1);
      check("nominal_start_once", start_cnt - s0, 1);
      handshake();
      check("nominal_back_to_load", in_ready, 1);

      // Gapped in_valid, junk ignored outside LOAD, downstream back-pressure
      stub_res = 8'h77;
      in_valid = 1'b1; in_data = 8'h11; in_mode = 1'b0; tick();
      in_valid = 1'b0; in_data = 8'hEE; in_mode = 1'b1; tick();
      in_valid = 1'b1; in_data = 8'h22; tick();
      in_valid = 1'b0; in_data = 8'hEE; tick();
      in_valid = 1'b1; in_data = 8'h33; tick();
      in_valid = 1'b0; in_data = 8'hEE; tick();
      in_valid = 1'b1; in_data = 8'h44; tick();
      in_data = 8'hEE;
      wait_out(n);
      check("gap_latency", n, 6);
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", out_valid, 1);
         check("stall_data", out_data, 8'h77);
         check("stall_in_ready", in_ready, 0);
         tick();
      end
      in_valid = 1'b0; in_mode = 1'b0;
      check("gap_ops", {a, b, c, d}, 32'h11223344);
      check("gap_mode", mode, 0);
      handshake();
      check("gap_back_to_load", in_ready, 1);

      // done outside WAIT is ignored
      force_done = 1'b1;
      tick(); tick();
      check("done_in_load", {in_ready, out_valid, core_clr}, 3'b100);
      force_done = 1'b0;

      // Reset while in WAIT
      stub_en = 1'b0;
      load_set(32'hDEADBEEF, 1'b1);
      tick(); tick(); tick(); tick();
      check("in_wait_busy", in_ready, 0);
      reset = 1'b1; tick(); reset = 1'b0;
      check("wait_rst_state", {in_ready, out_valid, err}, 3'b100);
      check("wait_rst_ops", {a, b, c, d, 7'b0, mode}, 40'h0);

      // Timeout: counter must start from zero again after the reset
      load_set(32'h01020304, 1'b0);
      wait_out(n);
      check("timeout_latency", n, 10);
      check("timeout_err", err, 1);
      check("timeout_data", out_data, 8'h00);
      handshake();

      // done coincides with the timeout cycle
      stub_en = 1'b1; stub_lat = 8; stub_res = 8'h33;
      load_set(32'h05060708, 1'b0);
      wait_out(n);
      check("edge_latency", n, 10);
      check("edge_err", err, 0);
      check("edge_data", out_data, 8'h33);
      handshake();

      // Reset mid-load discards partial bytes
      stub_lat = 4; stub_res = 8'h5A;
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b0);
      reset = 1'b1; tick(); tick(); reset = 1'b0;
      check("midload_rst_ready", in_ready, 1);
      check("midload_rst_a", a, 8'h00);
      s0 = start_cnt;
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h03, 1'b0);
      check("no_early_start", start_cnt - s0, 0);
      check("no_early_clr", {core_clr, start, in_ready}, 3'b001);
      send_byte(8'h04, 1'b0);
      wait_out(n);
      check("fresh_start_once", start_cnt - s0, 1);
      check("fresh_ops", {a, b, c, d}, 32'h01020304);
      check("fresh_mode", mode, 0);
      handshake();

      // Back-to-back sets with out_ready held high
      out_ready = 1'b1;
      c0 = clr_cnt; s0 = start_cnt;
      stub_res = 8'h5A;
      load_set(32'h10203040, 1'b1);
      wait_out(n);
      check("b2b1_data", out_data, 8'h5A);
      tick();
      check("b2b1_ready", {in_ready, out_valid}, 2'b10);
      stub_res = 8'h66;
      load_set(32'h50607080, 1'b0);
      wait_out(n);
      check("b2b2_data", out_data, 8'h66);
      check("b2b2_ops", {a, b, c, d}, 32'h50607080);
      tick();
      check("b2b2_ready", {in_ready, out_valid}, 2'b10);
      check("b2b_clr_count", clr_cnt - c0, 2);
      check("b2b_start_count", start_cnt - s0, 2);
      out_ready = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
